// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter fetch controller: FSM encoding,
// default widths and start address.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC_D_DEF       = 12;
  localparam int START_ADDR_DEF = 0;
  localparam int CYC_W          = 16;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold on stall or halt, else jump > branch > sequential.
module pc_next_calc #(
  parameter int D = 12
) (
  input  logic [D-1:0] prog_ctr,
  input  logic         stall,
  input  logic         halt,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic [D-1:0] target,
  input  logic [D-1:0] jump_addr,
  output logic [D-1:0] next_pc
);

  logic signed [D-1:0] offset;

  assign offset = target;

  // Two's-complement offset added at D bits; the carry out is dropped on purpose
  always_comb begin
    next_pc = prog_ctr;
    if (!stall && !halt) begin
      if (jump_en)        next_pc = jump_addr;
      else if (branch_en) next_pc = prog_ctr + $unsigned(offset);
      else                next_pc = prog_ctr + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: IDLE/RUN/DONE sequencing, PC register and
// a saturating count of RUN cycles since the last start.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int D          = PC_D_DEF,
  parameter int START_ADDR = START_ADDR_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [D-1:0]     target,
  input  logic             jump_en,
  input  logic [D-1:0]     jump_addr,
  input  logic             halt,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
  output logic             busy,
  output logic             done,
  output logic [CYC_W-1:0] cycle_ct
);

  state_t           state, state_nx;
  logic [D-1:0]     pc_calc, pc_nx;
  logic [CYC_W-1:0] ct_nx;

  pc_next_calc #(.D(D)) u_next (
    .prog_ctr  (prog_ctr),
    .stall     (stall),
    .halt      (halt),
    .jump_en   (jump_en),
    .branch_en (branch_en),
    .target    (target),
    .jump_addr (jump_addr),
    .next_pc   (pc_calc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      cycle_ct <= '0;
    end else begin
      state    <= state_nx;
      prog_ctr <= pc_nx;
      cycle_ct <= ct_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = prog_ctr;
    ct_nx    = cycle_ct;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          pc_nx    = D'(START_ADDR);
          ct_nx    = '0;
        end
      end
      RUN: begin
        // Stalled cycles still count; the counter sticks at all-ones
        if (cycle_ct != '1) ct_nx = cycle_ct + 1'b1;
        pc_nx = pc_calc;
        if (!stall && halt) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fetch_valid = (state == RUN) && !stall;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pc_fetch_ctrl;

  localparam int D = 12;
  localparam int START = 0;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0, stall = 1'b0, branch_en = 1'b0, jump_en = 1'b0, halt = 1'b0;
  logic [D-1:0]  target = '0, jump_addr = '0;
  logic [D-1:0]  prog_ctr;
  logic          fetch_valid, busy, done;
  logic [15:0]   cycle_ct;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_ctrl #(.D(D), .START_ADDR(START)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall),
    .branch_en(branch_en), .target(target), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt(halt), .prog_ctr(prog_ctr),
    .fetch_valid(fetch_valid), .busy(busy), .done(done), .cycle_ct(cycle_ct)
  );

  always #5 Clk = ~Clk;

  // Reference model: "running" / "finished" flags and integer PC arithmetic
  bit          m_run, m_fin;
  int unsigned m_pc, m_ct;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_run <= 0; m_fin <= 0; m_pc <= 0; m_ct <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1; m_fin <= 0; m_pc <= START; m_ct <= 0;
      end
    end else begin
      m_ct <= (m_ct >= 65535) ? 65535 : m_ct + 1;
      if (!stall) begin
        if (halt) begin
          m_run <= 0; m_fin <= 1;
        end else if (jump_en) m_pc <= jump_addr;
        else if (branch_en)   m_pc <= (m_pc + target) % (1 << D);
        else                  m_pc <= (m_pc + 1) % (1 << D);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("model prog_ctr", 32'(prog_ctr), m_pc);
    chk("model cycle_ct", 32'(cycle_ct), m_ct);
    chk("model busy", 32'(busy), 32'(m_run));
    chk("model done", 32'(done), 32'(m_fin));
    chk("model fetch_valid", 32'(fetch_valid), 32'(m_run && !stall));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; stall = 0; branch_en = 0; jump_en = 0; halt = 0;
  endtask

  task automatic jump_to(input int a);
    idle_in(); jump_en = 1; jump_addr = D'(a); tick(); jump_en = 0;
  endtask

  task automatic branch_from(input int a, input int t, input int exp, input string name);
    jump_to(a);
    branch_en = 1; target = D'(t); tick(); branch_en = 0;
    chk(name, 32'(prog_ctr), exp);
  endtask

  int ct0;

  initial begin
    #12;
    chk("reset prog_ctr", 32'(prog_ctr), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset cycle_ct", 32'(cycle_ct), 0);
    @(posedge Clk); #1 Reset = 0;
    tick(2);
    chk("idle holds busy", 32'(busy), 0);

    // start then three free-running cycles
    start = 1; tick(); start = 0;
    chk("start prog_ctr", 32'(prog_ctr), 0);
    chk("start fetch_valid", 32'(fetch_valid), 1);
    tick(3);
    chk("seq prog_ctr", 32'(prog_ctr), 3);
    chk("seq cycle_ct", 32'(cycle_ct), 3);

    branch_from(10, 'hFFB, 5, "branch -5");
    branch_from(3, 'hFFF, 2, "branch -1");
    branch_from(6, 0, 6, "branch 0");
    branch_from(4090, 20, 14, "branch wrap");
    jump_to(4095); tick();
    chk("seq wrap", 32'(prog_ctr), 0);
    chk("seq wrap busy", 32'(busy), 1);

    // halt beats jump and branch
    jump_to(9);
    halt = 1; jump_en = 1; branch_en = 1; jump_addr = 100; target = 3; tick(); idle_in();
    chk("halt prio done", 32'(done), 1);
    chk("halt prio pc", 32'(prog_ctr), 9);
    start = 1; tick(); start = 0;
    jump_to(9);
    jump_en = 1; branch_en = 1; jump_addr = 100; target = 3; tick(); idle_in();
    chk("jump over branch", 32'(prog_ctr), 100);

    // stall masks halt
    jump_to(7);
    ct0 = int'(cycle_ct);
    stall = 1; halt = 1; tick(2);
    chk("stall pc", 32'(prog_ctr), 7);
    chk("stall fetch_valid", 32'(fetch_valid), 0);
    chk("stall cycle_ct", 32'(cycle_ct), ct0 + 2);
    chk("stall busy", 32'(busy), 1);
    stall = 0; tick(); halt = 0;
    chk("release done", 32'(done), 1);
    chk("release pc", 32'(prog_ctr), 7);
    start = 1; tick(); start = 0;
    chk("start in done", 32'(done), 0);

    // asynchronous reset mid-run
    jump_to(50);
    chk("pre-reset pc", 32'(prog_ctr), 50);
    #2 Reset = 1;
    #1;
    chk("async reset pc", 32'(prog_ctr), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset fetch_valid", 32'(fetch_valid), 0);
    chk("async reset cycle_ct", 32'(cycle_ct), 0);
    @(posedge Clk); #1 Reset = 0;
    start = 1; tick(); start = 0;
    tick(2);
    halt = 1; tick(); halt = 0;
    chk("done before restart", 32'(done), 1);
    start = 1; tick(); start = 0;
    chk("restart pc", 32'(prog_ctr), 0);
    chk("restart done", 32'(done), 0);
    chk("restart busy", 32'(busy), 1);

    // randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      halt      = ($urandom_range(0, 29) == 0);
      jump_en   = ($urandom_range(0, 9) == 0);
      branch_en = ($urandom_range(0, 2) == 0);
      target    = D'($urandom);
      jump_addr = D'($urandom);
      Reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    Reset = 0; idle_in();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter D, default 12: program-counter width in bits; also the width of target and jump_addr.
REQ-002 Parameter START_ADDR, default 0: PC value loaded on every start.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  launch/relaunch program; pulse, sampled in IDLE and DONE only.
REQ-006 stall  input  1  freeze fetch this cycle.
REQ-007 branch_en  input  1  relative branch taken for the instruction at prog_ctr.
REQ-008 target  input  D  two's-complement relative offset from the branch-target lookup table.
REQ-009 jump_en  input  1  absolute jump for the instruction at prog_ctr.
REQ-010 jump_addr  input  D  absolute jump destination.
REQ-011 halt  input  1  instruction at prog_ctr is a halt.
REQ-012 prog_ctr  output  D  current fetch address (registered).
REQ-013 fetch_valid  output  1  instruction at prog_ctr executes this cycle.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  high in DONE; held until start or Reset.
REQ-016 cycle_ct  output  16  RUN cycles since last start, stalls included.

Function
REQ-017 FSM states IDLE, RUN, DONE; encoding comes from the shared package.
REQ-018 IDLE: start -> RUN, prog_ctr <= START_ADDR, cycle_ct <= 0; otherwise hold.
REQ-019 RUN, no stall, next-PC priority: halt > jump_en > branch_en > sequential.
REQ-020 halt -> DONE next edge; prog_ctr holds the halt address.
REQ-021 jump_en -> prog_ctr <= jump_addr.
REQ-022 branch_en -> prog_ctr <= (prog_ctr + target) mod 2**D; target 0 re-executes the same address, all-ones steps back 1.
REQ-023 Sequential -> prog_ctr <= (prog_ctr + 1) mod 2**D; 2**D-1 wraps to 0, with no flag and no state change.
REQ-024 RUN with stall=1: prog_ctr and state hold; halt, jump_en and branch_en are ignored that cycle.
REQ-025 fetch_valid = (state==RUN) && !stall; combinational; no other outputs depend combinationally on inputs.
REQ-026 cycle_ct increments every RUN cycle, including stalls; saturates at 16'hFFFF; holds in DONE and IDLE.
REQ-027 start in RUN is ignored.
REQ-028 DONE: done=1; start -> RUN with prog_ctr <= START_ADDR, cycle_ct <= 0, done drops on the same edge.
REQ-029 All next-PC arithmetic is D bits wide, with the carry discarded.

Reset
REQ-030 Reset asserted, at any time including mid-RUN: immediately state=IDLE, prog_ctr=0, cycle_ct=0, done=0, busy=0, fetch_valid=0.
REQ-031 After Reset deasserts, the block stays in IDLE until start is sampled high on a rising edge.

Structure
REQ-032 Package pc_pkg holds: the state enum (IDLE, RUN, DONE), default D=12, default START_ADDR=0, and the cycle_ct width constant 16.
REQ-033 One combinational sub-module, pc_next_calc, computes the next PC from prog_ctr, the control inputs and the operands; the FSM and registers stay in pc_fetch_ctrl.
REQ-034 The branch-target lookup table is instantiated outside this block; target arrives as a plain input.

Verification
REQ-035 Reset, start, 3 free cycles -> prog_ctr 0,1,2,3; fetch_valid=1; cycle_ct=3.
REQ-036 At prog_ctr=10, branch_en with target=12'hFFB -> 5; at 3 with 12'hFFF -> 2; at 6 with 0 -> 6.
REQ-037 At prog_ctr=4090, branch_en with target=20 -> 14; sequential from 4095 -> 0.
REQ-038 At prog_ctr=9, jump_en=branch_en=halt=1 -> DONE with prog_ctr=9; drop halt, repeat jump_en=branch_en with jump_addr=100 -> 100.
REQ-039 At prog_ctr=7, stall=1 with halt=1 for 2 cycles -> prog_ctr 7, fetch_valid=0, cycle_ct +2; release stall -> done=1, prog_ctr=7.
REQ-040 Reset asserted mid-RUN at prog_ctr=50 -> outputs zero with no clock edge; then DONE followed by start -> prog_ctr=0, done=0, busy=1.
